// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for shift_arbiter: op encodings, FSM states, datapath widths.
package shift_arbiter_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int AMT_WIDTH  = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_PASS2 = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/Shifter.sv
// Shared 16-bit shift datapath: Mode 0 = logical left, Mode 1 = arithmetic right.
module Shifter
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] Shift_In,
  input  logic [AMT_WIDTH-1:0]  Shift_Val,
  input  logic                  Mode,
  output logic [DATA_WIDTH-1:0] Shift_Out
);

  // The signed shift is kept in its own self-determined context so it stays arithmetic.
  always_comb begin
    Shift_Out = Shift_In << Shift_Val;
    if (Mode) begin
      Shift_Out = $unsigned($signed(Shift_In) >>> Shift_Val);
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters; one op in flight.
// Optional rotate-right support is built when SHIFT_ARB_ROR_EN is defined.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [3:0]       req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [3:0]       req1_amt,
  input  logic [1:0]       req1_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             out_err
);

  if (WIDTH != DATA_WIDTH) begin : g_width_check
    $error("shift_arbiter: WIDTH must be 16");
  end
  if ((RR_INIT != 0) && (RR_INIT != 1)) begin : g_rr_init_check
    $error("shift_arbiter: RR_INIT must be 0 or 1");
  end

  localparam logic RR_INIT_BIT = 1'(RR_INIT);

  state_e                 state_reg, state_next;
  logic                   ptr_reg;
  logic [WIDTH-1:0]       operand_reg;
  logic [WIDTH-1:0]       result_reg;
  logic [AMT_WIDTH-1:0]   amt_reg;
  op_e                    op_reg;
  logic                   id_reg;
  logic                   err_reg;

  logic [1:0]             req_valid;
  logic [1:0]             grant;
  logic [1:0]             ready_vec;
  logic                   accept;
  logic [WIDTH-1:0]       sel_data;
  logic [AMT_WIDTH-1:0]   sel_amt;
  logic [1:0]             sel_op;

  logic                   is_shift;
  logic                   is_ror;
  logic [AMT_WIDTH-1:0]   shift_val;
  logic                   shift_mode;
  logic [WIDTH-1:0]       shift_out;

  // Pointer only breaks ties; a lone requester is granted without touching it.
  assign req_valid = {req1_valid, req0_valid};
  assign grant[0]  = req_valid[0] & (~req_valid[1] | ~ptr_reg);
  assign grant[1]  = req_valid[1] & (~req_valid[0] |  ptr_reg);

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_vec[gi] = (state_reg == ST_IDLE) & grant[gi];
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;

  assign sel_data = grant[1] ? req1_data : req0_data;
  assign sel_amt  = grant[1] ? req1_amt  : req0_amt;
  assign sel_op   = grant[1] ? req1_op   : req0_op;

  assign is_shift = (op_reg == OP_SLL) || (op_reg == OP_SRA);
`ifdef SHIFT_ARB_ROR_EN
  assign is_ror   = (op_reg == OP_ROR);
`else
  assign is_ror   = 1'b0;
`endif

  // Shifter operands come only from registered state, never from request ports.
  always_comb begin
    shift_val  = amt_reg;
    shift_mode = (op_reg == OP_SRA);
`ifdef SHIFT_ARB_ROR_EN
    if ((state_reg == ST_PASS1) && is_ror) begin
      shift_val  = -amt_reg;
      shift_mode = 1'b0;
    end else if (state_reg == ST_PASS2) begin
      shift_mode = 1'b1;
    end
`endif
  end

  Shifter u_shifter (
    .Shift_In  (operand_reg),
    .Shift_Val (shift_val),
    .Mode      (shift_mode),
    .Shift_Out (shift_out)
  );

`ifdef SHIFT_ARB_ROR_EN
  logic [WIDTH-1:0] partial_reg;
  logic [WIDTH-1:0] ror_mask;
  logic [WIDTH-1:0] ror_merge;

  // Masking the arithmetic result strips the sign fill, leaving a logical right shift.
  assign ror_mask  = {WIDTH{1'b1}} >> amt_reg;
  assign ror_merge = partial_reg | (shift_out & ror_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      partial_reg <= '0;
    end else if ((state_reg == ST_PASS1) && is_ror) begin
      partial_reg <= shift_out;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_PASS1;
      ST_PASS1: state_next = is_ror ? ST_PASS2 : ST_DONE;
      ST_PASS2: state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= RR_INIT_BIT;
      operand_reg <= '0;
      amt_reg     <= '0;
      op_reg      <= OP_SLL;
      id_reg      <= 1'b0;
      result_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        operand_reg <= sel_data;
        amt_reg     <= sel_amt;
        op_reg      <= op_e'(sel_op);
        id_reg      <= grant[1];
        if (&req_valid) begin
          ptr_reg <= grant[0];
        end
      end
      if (state_reg == ST_PASS1) begin
        if (is_shift) begin
          result_reg <= shift_out;
          err_reg    <= 1'b0;
        end else if (!is_ror) begin
          result_reg <= operand_reg;
          err_reg    <= 1'b1;
        end
      end
`ifdef SHIFT_ARB_ROR_EN
      if (state_reg == ST_PASS2) begin
        result_reg <= ror_merge;
        err_reg    <= 1'b0;
      end
`endif
    end
  end

  assign out_valid = (state_reg == ST_DONE);
  assign out_data  = result_reg;
  assign out_id    = id_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: expected results queued at accept, compared at output.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_data;
  logic [3:0]  req0_amt;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_data;
  logic [3:0]  req1_amt;
  logic [1:0]  req1_op;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_id, out_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        id;
    logic        err;
    logic [3:0]  lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_arbiter #(.WIDTH(16), .RR_INIT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_op    (req1_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_err    (out_err)
  );

  // Reference: rotate written as the textbook two-shift OR, independent of the DUT's mask scheme.
  function automatic exp_t model(input logic id, input logic [1:0] op,
                                 input logic [15:0] x, input logic [3:0] n);
    exp_t e;
    logic signed [15:0] xs;
    xs = x;
    e.id = id; e.err = 1'b0; e.lat = 4'd2; e.data = x;
    case (op)
      2'b00: e.data = x << n;
      2'b01: e.data = xs >>> n;
`ifdef SHIFT_ARB_ROR_EN
      2'b10: begin
        e.data = (x >> n) | (x << (5'd16 - {1'b0, n}));
        e.lat  = 4'd3;
      end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic set_req(input int which, input logic v, input logic [1:0] op,
                         input logic [15:0] x, input logic [3:0] n);
    if (which == 0) begin
      req0_valid = v; req0_op = op; req0_data = x; req0_amt = n;
    end else begin
      req1_valid = v; req1_op = op; req1_data = x; req1_amt = n;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Issues one request alone, waits for its result; returns observed values and the queued expectation.
  task automatic run_op(input int which, input logic [1:0] op, input logic [15:0] x,
                        input logic [3:0] n, output logic [15:0] d, output logic id,
                        output logic err, output int lat, output exp_t e, output bit ok);
    int t0;
    ok = 0; d = '0; id = 1'b0; err = 1'b0; lat = 0; e = '0; t0 = 0;
    set_req(which, 1'b1, op, x, n);
    #1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if ((which == 0 ? req0_ready : req1_ready) === 1'b1) begin
        ok = 1; t0 = cyc;
        sb.push_back(model(which[0], op, x, n));
      end
      @(negedge clk);
    end
    set_req(which, 1'b0, op, x, n);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout req%0d: no ready within 20 cycles, required ready=1", which);
      return;
    end
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1; d = out_data; id = out_id; err = out_err; lat = cyc - t0;
      end else begin
        @(negedge clk);
      end
    end
    e = sb.pop_front();
    if (!ok) begin
      checks++; errors++;
      $display("FAIL result_timeout req%0d: out_valid=0 for 20 cycles, required out_valid=1", which);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h required 0000", out_data); end
    checks++;
    if ({out_id, out_err} !== 2'b00) begin errors++; $display("FAIL reset_id_err: got %b%b required 00", out_id, out_err); end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready); end
    $display("reset: out_valid=%b out_data=%h ready=%b%b", out_valid, out_data, req0_ready, req1_ready);
  endtask

  task automatic test_single(input string name, input int which, input logic [1:0] op,
                             input logic [15:0] x, input logic [3:0] n);
    logic [15:0] d; logic id, err; int lat; exp_t e; bit ok;
    out_ready = 1'b1;
    run_op(which, op, x, n, d, id, err, lat, e, ok);
    if (ok) begin
      checks++;
      if ({d, id, err} !== {e.data, e.id, e.err}) begin
        errors++;
        $display("FAIL %s: got data=%h id=%b err=%b, required data=%h id=%b err=%b",
                 name, d, id, err, e.data, e.id, e.err);
      end
      checks++;
      if (lat !== int'(e.lat)) begin
        errors++;
        $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
      end
      $display("%s: req%0d op=%b x=%h n=%0d -> data=%h id=%b err=%b lat=%0d",
               name, which, op, x, n, d, id, err, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_shifts();
    test_single("sll", 0, 2'b00, 16'h0001, 4'd4);
    test_single("sra", 1, 2'b01, 16'h8000, 4'd3);
    test_single("sll_max", 1, 2'b00, 16'hFFFF, 4'd15);
    test_single("sra_pos", 0, 2'b01, 16'h7F00, 4'd15);
  endtask

  task automatic test_ror();
    logic [15:0] xs [4];
    logic [3:0]  ns [4];
    xs[0] = 16'h1234; ns[0] = 4'd4;
    xs[1] = 16'h8001; ns[1] = 4'd1;
    xs[2] = 16'hABCD; ns[2] = 4'd0;
    xs[3] = 16'hF00F; ns[3] = 4'd15;
    for (int i = 0; i < 4; i++) begin
      test_single("ror", i % 2, 2'b10, xs[i], ns[i]);
    end
  endtask

  task automatic test_illegal();
    test_single("illegal_op11", 1, 2'b11, 16'h5A5A, 4'd3);
    test_single("illegal_op11", 0, 2'b11, 16'h5A5A, 4'd0);
  endtask

  task automatic test_round_robin();
    bit ok; logic g, both; int t0, prev_t; int prev_lat; exp_t e;
    do_reset();
    out_ready = 1'b1;
    prev_t = 0; prev_lat = 0; t0 = 0;
    set_req(0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
    set_req(1, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
    #1;
    for (int k = 0; k < 8; k++) begin
      ok = 0; g = 1'b0; both = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
          ok = 1; g = req1_ready; both = req0_ready & req1_ready; t0 = cyc;
          if (g) sb.push_back(model(1'b1, req1_op, req1_data, req1_amt));
          else   sb.push_back(model(1'b0, req0_op, req0_data, req0_amt));
        end else begin
          @(negedge clk);
        end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL rr_grant_timeout[%0d]: no grant within 20 cycles, required one", k);
        break;
      end
      checks++;
      if ({both, g} !== {1'b0, 1'(k % 2)}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got both=%b grant=%b, required both=0 grant=%0d", k, both, g, k % 2);
      end
      if (k > 0) begin
        checks++;
        if (t0 - prev_t !== prev_lat + 1) begin
          errors++;
          $display("FAIL rr_throughput[%0d]: got spacing %0d required %0d", k, t0 - prev_t, prev_lat + 1);
        end
      end
      @(negedge clk);
      set_req(int'(g), 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        if (out_valid === 1'b1) ok = 1;
        else @(negedge clk);
      end
      e = sb.pop_front();
      if (!ok) begin
        checks++; errors++;
        $display("FAIL rr_result_timeout[%0d]: out_valid=0 for 20 cycles, required 1", k);
        break;
      end
      checks++;
      if ({out_data, out_id, out_err} !== {e.data, e.id, e.err}) begin
        errors++;
        $display("FAIL rr_result[%0d]: got data=%h id=%b err=%b, required data=%h id=%b err=%b",
                 k, out_data, out_id, out_err, e.data, e.id, e.err);
      end
      checks++;
      if (cyc - t0 !== int'(e.lat)) begin
        errors++;
        $display("FAIL rr_latency[%0d]: got %0d required %0d", k, cyc - t0, e.lat);
      end
      $display("rr[%0d]: grant=%b data=%h err=%b lat=%0d", k, g, out_data, out_err, cyc - t0);
      prev_t = t0; prev_lat = int'(e.lat);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok; int t0; logic [15:0] d0; logic id0; exp_t e;
    out_ready = 1'b0;
    ok = 0; t0 = 0; d0 = '0; id0 = 1'b0;
    set_req(0, 1'b1, 2'b00, 16'h00F0, 4'd2);
    #1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req0_ready === 1'b1) begin ok = 1; t0 = cyc; sb.push_back(model(1'b0, 2'b00, 16'h00F0, 4'd2)); end
      else @(negedge clk);
    end
    @(negedge clk);
    set_req(0, 1'b0, 2'b00, 16'h00F0, 4'd2);
    set_req(1, 1'b1, 2'b01, 16'h8421, 4'd1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid === 1'b1) begin ok = 1; d0 = out_data; id0 = out_id; end
      else @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL bp_result_timeout: out_valid=0 for 20 cycles, required 1");
    end
    e = sb.pop_front();
    checks++;
    if ({d0, id0} !== {e.data, e.id}) begin
      errors++;
      $display("FAIL bp_result: got data=%h id=%b required data=%h id=%b", d0, id0, e.data, e.id);
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_id, req1_ready} !== {1'b1, d0, id0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h id=%b ready1=%b, required valid=1 data=%h id=%b ready1=0",
                 j, out_valid, out_data, out_id, req1_ready, d0, id0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_resume: got valid=%b ready1=%b required valid=0 ready1=1", out_valid, req1_ready);
    end
    t0 = cyc;
    sb.push_back(model(1'b1, 2'b01, 16'h8421, 4'd1));
    @(negedge clk);
    set_req(1, 1'b0, 2'b01, 16'h8421, 4'd1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid === 1'b1) ok = 1;
      else @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if ({ok, out_data, out_id, out_err, 4'(cyc - t0)} !== {1'b1, e.data, e.id, e.err, e.lat}) begin
      errors++;
      $display("FAIL bp_after: got ok=%b data=%h id=%b err=%b lat=%0d, required data=%h id=%b err=%b lat=%0d",
               ok, out_data, out_id, out_err, cyc - t0, e.data, e.id, e.err, e.lat);
    end
    $display("backpressure: held data=%h id=%b, follow-up data=%h", d0, id0, out_data);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic id, err; int lat; exp_t e; bit ok; bit seen;
    logic [1:0] op_mid;
`ifdef SHIFT_ARB_ROR_EN
    op_mid = 2'b10;
`else
    op_mid = 2'b00;
`endif
    do_reset();
    out_ready = 1'b1;
    // Tie-break on the first op moves the pointer away from RR_INIT.
    set_req(1, 1'b1, 2'b00, 16'h0003, 4'd1);
    run_op(0, 2'b00, 16'h0003, 4'd1, d, id, err, lat, e, ok);
    req1_valid = 1'b0;
    checks++;
    if ({ok, d, id} !== {1'b1, e.data, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_first: got ok=%b data=%h id=%b required data=%h id=0", ok, d, id, e.data);
    end
    @(negedge clk);
    set_req(1, 1'b1, op_mid, 16'h1234, 4'd4);
    #1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req1_ready === 1'b1) ok = 1;
      else @(negedge clk);
    end
    @(negedge clk);
    set_req(1, 1'b0, op_mid, 16'h1234, 4'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ok, out_valid, out_data} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL rstmid_state: got accepted=%b out_valid=%b out_data=%h required 1 0 0000", ok, out_valid, out_data);
    end
    set_req(0, 1'b1, 2'b00, 16'h0001, 4'd0);
    set_req(1, 1'b1, 2'b00, 16'h0001, 4'd0);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_pointer: got ready=%b%b required 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstmid_stale: got out_valid=1 after reset, required 0");
    end
    $display("reset_mid: out_valid=%b stale=%b", out_valid, seen);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    set_req(0, 1'b0, 2'b00, 16'h0000, 4'd0);
    set_req(1, 1'b0, 2'b00, 16'h0000, 4'd0);
    @(negedge clk);
    test_reset();
    test_shifts();
    test_ror();
    test_illegal();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
